// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board logic: FSM states, colour
// codes, winner encodings and the eight winning lines.
package ttt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    MARK,
    CHECK,
    OVER
  } state_t;

  localparam logic [11:0] BLUE_CODE   = 12'h000;
  localparam logic [11:0] YELLOW_CODE = 12'h001;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_BLUE   = 2'b01;
  localparam logic [1:0] WIN_YELLOW = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  // Zero-based square indices of each line; entry i is win_line code i+1.
  localparam logic [3:0] LINE_SQ [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Lowest-numbered line fully owned by player, 0 when none.
  function automatic logic [3:0] find_win(input logic [8:0] occ,
                                          input logic [8:0] owner,
                                          input logic       player);
    logic [8:0] mine;
    logic [3:0] res;
    mine = occ & (player ? owner : ~owner);
    res  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (res == '0 && mine[LINE_SQ[i][0]] && mine[LINE_SQ[i][1]] &&
          mine[LINE_SQ[i][2]])
        res = 4'(i + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/square_decode.sv
// Combinational cursor-to-square decode; 1..9 row-major, 0 outside the grid.
module square_decode #(
  parameter logic [11:0] COL1_L = 12'd8,
  parameter logic [11:0] COL2_L = 12'd344,
  parameter logic [11:0] COL3_L = 12'd680,
  parameter logic [11:0] COL3_R = 12'd1015,
  parameter logic [11:0] ROW1_T = 12'd10,
  parameter logic [11:0] ROW2_T = 12'd263,
  parameter logic [11:0] ROW3_T = 12'd515,
  parameter logic [11:0] ROW3_B = 12'd767
) (
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [3:0]  square
);

  logic [1:0] col;
  logic [1:0] row;
  logic [3:0] base;

  // Column/row band lookup, then combine into a square number.
  always_comb begin
    col = 2'd0;
    row = 2'd0;
    if (xpos >= COL1_L && xpos < COL2_L)       col = 2'd1;
    else if (xpos >= COL2_L && xpos < COL3_L)  col = 2'd2;
    else if (xpos >= COL3_L && xpos <= COL3_R) col = 2'd3;
    if (ypos >= ROW1_T && ypos < ROW2_T)       row = 2'd1;
    else if (ypos >= ROW2_T && ypos < ROW3_T)  row = 2'd2;
    else if (ypos >= ROW3_T && ypos <= ROW3_B) row = 2'd3;
    case (row)
      2'd2:    base = 4'd3;
      2'd3:    base = 4'd6;
      default: base = 4'd0;
    endcase
    square = (row == 2'd0 || col == 2'd0) ? 4'd0 : base + {2'b00, col};
  end

endmodule

// File: rtl/board_state_ctrl.sv
// Tic-tac-toe game state: click decode, turn alternation, occupancy/owner,
// win and draw detection. Optional turn timeout via `MOVE_TIMEOUT_EN.
module board_state_ctrl
  import ttt_pkg::*;
#(
  parameter logic [11:0] COL1_L = 12'd8,
  parameter logic [11:0] COL2_L = 12'd344,
  parameter logic [11:0] COL3_L = 12'd680,
  parameter logic [11:0] COL3_R = 12'd1015,
  parameter logic [11:0] ROW1_T = 12'd10,
  parameter logic [11:0] ROW2_T = 12'd263,
  parameter logic [11:0] ROW3_T = 12'd515,
  parameter logic [11:0] ROW3_B = 12'd767,
  parameter int unsigned TIMEOUT_FRAMES = 600
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         start_en,
  input  logic         choice_en,
  input  logic         mouse_left,
  input  logic [11:0]  mouse_xpos,
  input  logic [11:0]  mouse_ypos,
  input  logic         first_color,
  input  logic         new_game,
  input  logic         vsync_in,
  output logic [8:0]   square_occ,
  output logic [107:0] square_color,
  output logic         cur_player,
  output logic         game_over,
  output logic [1:0]   winner,
  output logic [3:0]   win_line
);

  state_t     state, state_nxt;
  logic       mouse_left_prev;
  logic       click;
  logic       play_ok;
  logic [3:0] dec_sq;
  logic [3:0] latched_sq;
  logic [8:0] sq_bit;
  logic [8:0] owner;
  logic [3:0] win_ln;
  logic       clear_board, load_first, latch_sq, do_mark;
  logic       set_win, set_draw, toggle, timeout_hit;

  square_decode #(
    .COL1_L(COL1_L), .COL2_L(COL2_L), .COL3_L(COL3_L), .COL3_R(COL3_R),
    .ROW1_T(ROW1_T), .ROW2_T(ROW2_T), .ROW3_T(ROW3_T), .ROW3_B(ROW3_B)
  ) u_decode (
    .xpos  (mouse_xpos),
    .ypos  (mouse_ypos),
    .square(dec_sq)
  );

  assign click   = mouse_left & ~mouse_left_prev;
  assign play_ok = start_en & ~choice_en;
  assign sq_bit  = (latched_sq == 4'd0) ? 9'd0 : 9'd1 << (latched_sq - 4'd1);
  assign win_ln  = find_win(square_occ, owner, cur_player);

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and datapath strobes; new_game, then leaving play, override the per-state decision.
  always_comb begin
    state_nxt   = state;
    clear_board = 1'b0;
    load_first  = 1'b0;
    latch_sq    = 1'b0;
    do_mark     = 1'b0;
    set_win     = 1'b0;
    set_draw    = 1'b0;
    toggle      = 1'b0;
    case (state)
      IDLE: if (play_ok) begin
        state_nxt   = PLAY;
        clear_board = 1'b1;
        load_first  = 1'b1;
      end
      PLAY: if (click) begin
        state_nxt = MARK;
        latch_sq  = 1'b1;
      end
      MARK: begin
        if (sq_bit != 9'd0 && (square_occ & sq_bit) == 9'd0) begin
          do_mark   = 1'b1;
          state_nxt = CHECK;
        end else begin
          state_nxt = PLAY;
        end
      end
      CHECK: begin
        if (win_ln != 4'd0) begin
          set_win   = 1'b1;
          state_nxt = OVER;
        end else if (&square_occ) begin
          set_draw  = 1'b1;
          state_nxt = OVER;
        end else begin
          toggle    = 1'b1;
          state_nxt = PLAY;
        end
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
    if (new_game || !play_ok) begin
      latch_sq    = 1'b0;
      do_mark     = 1'b0;
      set_win     = 1'b0;
      set_draw    = 1'b0;
      toggle      = 1'b0;
      clear_board = 1'b1;
      load_first  = play_ok;
      state_nxt   = play_ok ? PLAY : IDLE;
    end
  end

  // Click edge register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) mouse_left_prev <= 1'b0;
    else      mouse_left_prev <= mouse_left;
  end

  // Board, turn and result registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      square_occ <= '0;
      owner      <= '0;
      latched_sq <= '0;
      cur_player <= 1'b0;
      game_over  <= 1'b0;
      winner     <= WIN_NONE;
      win_line   <= '0;
    end else begin
      if (latch_sq) latched_sq <= dec_sq;
      if (clear_board) begin
        square_occ <= '0;
        owner      <= '0;
        game_over  <= 1'b0;
        winner     <= WIN_NONE;
        win_line   <= '0;
      end
      if (do_mark) begin
        square_occ <= square_occ | sq_bit;
        owner      <= cur_player ? (owner | sq_bit) : (owner & ~sq_bit);
      end
      if (set_win) begin
        winner    <= cur_player ? WIN_YELLOW : WIN_BLUE;
        win_line  <= win_ln;
        game_over <= 1'b1;
      end
      if (set_draw) begin
        winner    <= WIN_DRAW;
        game_over <= 1'b1;
      end
      if (load_first)                cur_player <= first_color;
      else if (toggle || timeout_hit) cur_player <= ~cur_player;
    end
  end

  // Per-square colour code expansion; empty squares read as blue code.
  always_comb begin
    square_color = '0;
    for (int unsigned k = 0; k < 9; k++)
      square_color[12*k +: 12] = (square_occ[k] && owner[k]) ? YELLOW_CODE : BLUE_CODE;
  end

`ifdef MOVE_TIMEOUT_EN
  logic       vsync_prev;
  logic [9:0] frame_cnt;
  logic       vsync_rise;

  assign vsync_rise  = vsync_in & ~vsync_prev;
  assign timeout_hit = (state == PLAY) && vsync_rise &&
                       (frame_cnt + 10'd1 == TIMEOUT_FRAMES[9:0]);

  // Frame counter for the turn timeout; restarts on any move or fresh turn start.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_prev <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (clear_board || load_first || do_mark || timeout_hit)
        frame_cnt <= '0;
      else if (state == PLAY && vsync_rise)
        frame_cnt <= frame_cnt + 10'd1;
    end
  end
`else
  localparam int unsigned TIMEOUT_FRAMES_UNUSED = TIMEOUT_FRAMES;
  logic vsync_unused;
  assign vsync_unused = vsync_in;
  assign timeout_hit  = 1'b0;
`endif

endmodule
